gamma_xor_coder: RTL and testbench
==================================

Name: gamma_xor_coder

Overview:
- Downstream consumer of the gamma extender.
- Takes the DATA_W-bit gamma word from the extender and XORs it into a valid/ready input data stream, one gamma word per data word, in frames of FRAME_LEN words.
- Emits the coded stream through a registered valid/ready output with a last-word flag.
- Pulses gamma_step so the upstream random source advances once per consumed gamma word.

Parameters:
- DATA_W, 8: data and gamma word width; equals the extender output width.
- FRAME_LEN, 16: words per frame; legal range 1..65535.
- CNT_W, 16: width of the completed-frame counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin-frame request; sampled only in IDLE.
- gamma_in  in  DATA_W  current gamma word from the extender; upstream holds it stable until a gamma_step edge.
- gamma_step  out  1  combinational pulse, high in exactly the cycles a data word is accepted.
- s_data  in  DATA_W  plaintext input word.
- s_valid  in  1  input word valid.
- s_ready  out  1  input word accepted when s_valid && s_ready.
- m_data  out  DATA_W  coded output word (registered).
- m_valid  out  1  output word valid (registered).
- m_ready  in  1  downstream accepts when m_valid && m_ready.
- m_last  out  1  marks the final word of a frame; qualified by m_valid.
- busy  out  1  high whenever state is not IDLE.
- frame_cnt  out  CNT_W  completed frames; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, word counter = 0, frame_cnt = 0.
  - m_valid = 0, m_last = 0, m_data = 0.
  - s_ready, gamma_step and busy read 0 while reset is held.
- Reset asserted mid-frame aborts the frame immediately. Any pending output word is lost, and frame_cnt does not increment.
- IDLE state:
  - s_ready = 0.
  - start = 1 moves to RUN on the next edge and sets word counter = 0.
  - A word presented in the start cycle is not accepted; acceptance begins the following cycle.
- RUN state:
  - s_ready = !m_valid || m_ready (single output register; a simultaneous drain and refill in one cycle is allowed).
  - On accept: m_data <= s_data ^ gamma_in, m_valid <= 1, m_last <= (counter == FRAME_LEN-1), counter increments, and gamma_step = 1 in that same cycle.
  - Latency from accept to m_valid is 1 cycle.
  - Accepting the final word (counter == FRAME_LEN-1) transitions to DRAIN.
- DRAIN state:
  - s_ready = 0.
  - When m_valid && m_ready (the last word leaves), the next state is IDLE, frame_cnt increments, m_valid clears and m_last clears.
- Output hold:
  - With m_valid = 1 and m_ready = 0, m_data and m_last stay stable and s_ready = 0.
  - When an output handshake occurs with no new accept, m_valid clears on the next edge.
- start outside IDLE is ignored; there is no queuing of start requests.
- FRAME_LEN = 1: the first accepted word carries m_last = 1 and moves straight to DRAIN.
- Counter width is $clog2(FRAME_LEN+1). The counter never exceeds FRAME_LEN-1 and clears on entry to RUN.
- frame_cnt rolls from 2^CNT_W-1 to 0 without any flag.
- gamma_in is sampled only on accept cycles; changes at other times have no effect.

Optional Feature:
- Macro: GAMMA_XOR_CODER_PARITY_EN.
- Defined:
  - Adds output port m_parity (1 bit), registered alongside m_data.
  - Value = XOR-reduction of the coded word (even parity).
  - Reset value 0; held stable under backpressure like m_data.
- Undefined:
  - Port and logic are absent; all other behaviour is identical.

Test Plan:
- Basic frame:
  - Stimulus: FRAME_LEN=4, gamma_in=8'hA5 constant; start, then s_data 00, FF, 3C, 5A back-to-back with m_ready=1.
  - Required: m_data A5, 5A, 99, FF on consecutive cycles, each one cycle after its accept.
  - Required: m_last only on FF; 4 gamma_step pulses; frame_cnt goes 0 -> 1; busy falls the cycle after the last output handshake.
- Backpressure:
  - Stimulus: hold m_ready=0 for 3 cycles after the first accept.
  - Required: m_data stays at A5, s_ready=0, and no gamma_step pulses during the stall.
  - Required: on release, the stream resumes with no loss or duplication.
- Gamma stepping:
  - Stimulus: gamma_in changes to 8'h0F, 8'hF0 between accepts; s_data = 8'h33 each time.
  - Required: outputs 3C, C3.
  - Required: changes to gamma_in in idle-gap cycles do not affect the outputs.
- Start handling:
  - Stimulus: start asserted with s_valid=1 in the same cycle.
  - Required: no accept in that cycle; accept in the next.
  - Stimulus: start pulsed during RUN and during DRAIN.
  - Required: ignored, and the counter is not reset.
- Reset mid-frame:
  - Stimulus: assert rst_n=0 after 2 of 4 words, with m_valid=1.
  - Required: m_valid, m_last, busy and frame_cnt all read 0 immediately (asynchronously).
  - Required: a following full frame completes normally with frame_cnt = 1.
- FRAME_LEN=1 and parity:
  - Stimulus: FRAME_LEN=1, gamma_in=8'h01, s_data=8'h06.
  - Required: m_data=07, m_last=1, state returns to IDLE after the handshake.
  - Required with GAMMA_XOR_CODER_PARITY_EN defined: m_parity=1.

Source files
------------

// File: rtl/gamma_xor_coder.sv
// XORs one gamma word into each accepted data word, framed in FRAME_LEN words, registered valid/ready output.
// Optional even-parity output m_parity when GAMMA_XOR_CODER_PARITY_EN is defined.
module gamma_xor_coder #(
    parameter int DATA_W    = 8,
    parameter int FRAME_LEN = 16,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] gamma_in,
    output logic              gamma_step,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic [CNT_W-1:0]  frame_cnt
`ifdef GAMMA_XOR_CODER_PARITY_EN
    ,
    output logic              m_parity
`endif
);

    // state | meaning
    // IDLE  | waiting for start, input closed
    // RUN   | accepting words, XORing gamma, counting toward FRAME_LEN
    // DRAIN | final word held in output register until it is taken
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int             CW      = $clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0]  LP_LAST = CW'(FRAME_LEN - 1);

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [DATA_W-1:0]   r_data;
    logic                r_valid;
    logic                r_last;
    logic [CNT_W-1:0]    r_frame_cnt;
`ifdef GAMMA_XOR_CODER_PARITY_EN
    logic                r_parity;
`endif

    logic                w_s_ready;
    logic                w_accept;
    logic                w_is_last;
    logic [DATA_W-1:0]   w_coded;

    // Single output register: a pending word may leave in the same cycle a new one enters.
    assign w_s_ready = (r_state == ST_RUN) && (!r_valid || m_ready);
    assign w_accept  = w_s_ready && s_valid;
    assign w_is_last = (r_cnt == LP_LAST);
    assign w_coded   = s_data ^ gamma_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_frame_cnt <= '0;
`ifdef GAMMA_XOR_CODER_PARITY_EN
            r_parity    <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_RUN;
                        r_cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    if (w_accept) begin
                        r_data  <= w_coded;
                        r_valid <= 1'b1;
                        r_last  <= w_is_last;
`ifdef GAMMA_XOR_CODER_PARITY_EN
                        r_parity <= ^w_coded;
`endif
                        if (w_is_last) r_state <= ST_DRAIN;
                        else           r_cnt   <= r_cnt + CW'(1);
                    end else if (r_valid && m_ready) begin
                        r_valid <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (r_valid && m_ready) begin
                        r_state     <= ST_IDLE;
                        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                        r_valid     <= 1'b0;
                        r_last      <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign s_ready    = w_s_ready;
    assign gamma_step = w_accept;
    assign m_data     = r_data;
    assign m_valid    = r_valid;
    assign m_last     = r_last;
    assign busy       = (r_state != ST_IDLE);
    assign frame_cnt  = r_frame_cnt;
`ifdef GAMMA_XOR_CODER_PARITY_EN
    assign m_parity   = r_parity;
`endif

endmodule

// File: tb/tb_gamma_xor_coder.sv
// Self-checking bench for gamma_xor_coder: per-cycle behavioural model plus directed literal checks.
// FRAME_LEN=4 instance carries the main tests; a FRAME_LEN=1, CNT_W=2 instance covers the single-word frame and wrap.
module tb_gamma_xor_coder;

    localparam int FL = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        start = 0, sv = 0, mr = 0;
    logic [7:0]  g = 0, sd = 0;
    logic        gs, srdy, mv, ml, busy;
    logic [7:0]  md;
    logic [15:0] fc;
    logic        par;

    logic        start1 = 0, sv1 = 0, mr1 = 0;
    logic [7:0]  g1 = 0, sd1 = 0;
    logic        gs1, srdy1, mv1, ml1, busy1;
    logic [7:0]  md1;
    logic [1:0]  fc1;
    logic        par1;

    gamma_xor_coder #(.DATA_W(8), .FRAME_LEN(FL), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .gamma_in(g), .gamma_step(gs),
        .s_data(sd), .s_valid(sv), .s_ready(srdy), .m_data(md), .m_valid(mv),
        .m_ready(mr), .m_last(ml), .busy(busy), .frame_cnt(fc)
`ifdef GAMMA_XOR_CODER_PARITY_EN
        , .m_parity(par)
`endif
    );

    gamma_xor_coder #(.DATA_W(8), .FRAME_LEN(1), .CNT_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .gamma_in(g1), .gamma_step(gs1),
        .s_data(sd1), .s_valid(sv1), .s_ready(srdy1), .m_data(md1), .m_valid(mv1),
        .m_ready(mr1), .m_last(ml1), .busy(busy1), .frame_cnt(fc1)
`ifdef GAMMA_XOR_CODER_PARITY_EN
        , .m_parity(par1)
`endif
    );

`ifndef GAMMA_XOR_CODER_PARITY_EN
    assign par  = 1'b0;
    assign par1 = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: frame phase, words taken so far, the one pending output word, frames done.
    int         mode = 0;          // 0 idle, 1 taking words, 2 waiting for last word to leave
    int         taken = 0;
    bit         ov = 0, ol = 0;
    logic [7:0] od = 0;
    int         frames = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode = 0; taken = 0; ov = 0; ol = 0; od = 0; frames = 0;
        end else if (mode == 0) begin
            if (start) begin mode = 1; taken = 0; end
        end else if (mode == 1) begin
            if (sv && (!ov || mr)) begin
                od = sd ^ g;
                ov = 1;
                taken = taken + 1;
                ol = (taken == FL);
                if (ol) mode = 2;
            end else if (ov && mr) begin
                ov = 0;
            end
        end else begin
            if (ov && mr) begin
                mode = 0; ov = 0; ol = 0;
                frames = (frames + 1) % 65536;
            end
        end
    end

    logic [7:0] obs_d[$];
    logic       obs_l[$];
    int         steps = 0;

    always @(negedge clk) begin
        logic exp_rdy;
        exp_rdy = (mode == 1) && (!ov || mr);
        chk("s_ready", srdy, exp_rdy);
        chk("gamma_step", gs, exp_rdy && sv);
        chk("busy", busy, mode != 0);
        chk("m_valid", mv, ov);
        if (ov) begin
            chk("m_data", md, od);
            chk("m_last", ml, ol);
`ifdef GAMMA_XOR_CODER_PARITY_EN
            chk("m_parity", par, ^od);
`endif
        end
        chk("frame_cnt", fc, frames);
        if (mv && mr) begin
            obs_d.push_back(md);
            obs_l.push_back(ml);
        end
        if (gs) steps++;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic start_frame();
        start = 1; tick(); start = 0;
    endtask

    task automatic push(input logic [7:0] d);
        int n;
        sv = 1; sd = d; n = 0;
        @(negedge clk);
        while (!srdy && n < 50) begin @(negedge clk); n++; end
        chk("push_timeout", n < 50, 1);
        tick();
        sv = 0;
    endtask

    task automatic clear_obs();
        obs_d.delete(); obs_l.delete(); steps = 0;
    endtask

    task automatic check_frame(input string nm, input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] e[4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        chk({nm, "_count"}, obs_d.size(), 4);
        for (int i = 0; i < 4 && i < obs_d.size(); i++) begin
            chk({nm, "_data"}, obs_d[i], e[i]);
            chk({nm, "_last"}, obs_l[i], i == 3);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 0;
        #1 chk("reset_m_valid", mv, 0);
        chk("reset_m_data", md, 0);
        chk("reset_m_last", ml, 0);
        chk("reset_frame_cnt", fc, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1;
        tick();

        // FRAME_LEN=1 instance, five frames on a 2-bit frame counter
        for (int k = 0; k < 5; k++) begin
            start1 = 1; tick(); start1 = 0;
            sv1 = 1; sd1 = 8'h06; g1 = 8'h01; mr1 = 0;
            @(negedge clk); chk("fl1_s_ready", srdy1, 1); chk("fl1_step", gs1, 1);
            tick(); sv1 = 0;
            @(negedge clk);
            chk("fl1_m_data", md1, 8'h07);
            chk("fl1_m_last", ml1, 1);
            chk("fl1_m_valid", mv1, 1);
            chk("fl1_busy_drain", busy1, 1);
            chk("fl1_s_ready_drain", srdy1, 0);
`ifdef GAMMA_XOR_CODER_PARITY_EN
            chk("fl1_parity", par1, 1);
`endif
            tick(); mr1 = 1;
            @(negedge clk); chk("fl1_hs_valid", mv1, 1);
            tick(); mr1 = 0;
            @(negedge clk);
            chk("fl1_idle_valid", mv1, 0);
            chk("fl1_idle_last", ml1, 0);
            chk("fl1_idle_busy", busy1, 0);
            chk("fl1_frame_cnt", fc1, (k + 1) % 4);
            tick();
        end

        // Basic frame
        mr = 1; g = 8'hA5; clear_obs();
        start_frame();
        push(8'h00); push(8'hFF); push(8'h3C); push(8'h5A);
        repeat (3) tick();
        check_frame("basic", 8'hA5, 8'h5A, 8'h99, 8'hFF);
        chk("basic_steps", steps, 4);
        chk("basic_frame_cnt", fc, 1);
        chk("basic_busy", busy, 0);

        // Backpressure
        clear_obs();
        start_frame();
        push(8'h00);
        mr = 0; sv = 1; sd = 8'hFF;
        repeat (3) begin
            @(negedge clk);
            chk("stall_m_data", md, 8'hA5);
            chk("stall_s_ready", srdy, 0);
            chk("stall_step", gs, 0);
        end
        tick(); mr = 1;
        push(8'hFF); push(8'h3C); push(8'h5A);
        repeat (3) tick();
        check_frame("bp", 8'hA5, 8'h5A, 8'h99, 8'hFF);
        chk("bp_frame_cnt", fc, 2);

        // Gamma stepping with idle-gap gamma changes
        clear_obs();
        start_frame();
        g = 8'h0F; push(8'h33);
        g = 8'h55; repeat (2) tick();
        g = 8'hF0; push(8'h33);
        g = 8'hAA; tick();
        g = 8'h00; push(8'h33); push(8'h33);
        repeat (3) tick();
        check_frame("gamma", 8'h3C, 8'hC3, 8'h33, 8'h33);

        // Start handling
        clear_obs();
        g = 8'h00; sd = 8'h11; sv = 1; start = 1;
        @(negedge clk); chk("start_cycle_ready", srdy, 0); chk("start_cycle_step", gs, 0);
        tick(); start = 0;
        @(negedge clk); chk("post_start_ready", srdy, 1); chk("post_start_step", gs, 1);
        tick(); sv = 0;
        start = 1; push(8'h22); start = 0;
        push(8'h44); push(8'h88);
        mr = 0; start = 1; tick(); start = 0; tick(); mr = 1;
        repeat (4) tick();
        check_frame("start", 8'h11, 8'h22, 8'h44, 8'h88);
        chk("start_busy", busy, 0);
        chk("start_frame_cnt", fc, 4);

        // Reset mid-frame
        clear_obs();
        start_frame();
        push(8'h01); push(8'h02);
        sv = 1; sd = 8'h03;
        #3 rst_n = 0;
        #1 chk("rst_m_valid", mv, 0);
        chk("rst_m_last", ml, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_cnt", fc, 0);
        chk("rst_s_ready", srdy, 0);
        chk("rst_step", gs, 0);
        sv = 0;
        @(posedge clk); #3 rst_n = 1;
        tick();
        clear_obs(); g = 8'hA5;
        start_frame();
        push(8'h00); push(8'hFF); push(8'h3C); push(8'h5A);
        repeat (3) tick();
        check_frame("after_rst", 8'hA5, 8'h5A, 8'h99, 8'hFF);
        chk("after_rst_frame_cnt", fc, 1);

        // Randomized traffic checked cycle by cycle against the model
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 7) == 0);
            sv    = ($urandom_range(0, 3) != 0);
            mr    = ($urandom_range(0, 3) != 0);
            g     = 8'($urandom);
            sd    = 8'($urandom);
            tick();
        end
        start = 0; sv = 0; mr = 1;
        repeat (10) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
